// File: rtl/rd_scoreboard_pkg.sv
// Shared pipeline definitions for the register scoreboard: type-field masks,
// register index type and small decode helpers.
package rd_scoreboard_pkg;

    localparam int REG_W = 5;
    localparam int OUT_W = 7;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Any bit under NO_RD_MASK means the instruction writes no rd;
    // any bit under NO_RS2_MASK means it reads no rs2.
    localparam logic [4:0] NO_RD_MASK  = 5'b11000;
    localparam logic [4:0] NO_RS2_MASK = 5'b00111;

    function automatic logic has_rd(input logic [4:0] t);
        return (t & NO_RD_MASK) == 5'b00000;
    endfunction

    function automatic logic has_rs2(input logic [4:0] t);
        return (t & NO_RS2_MASK) == 5'b00000;
    endfunction

endpackage

// File: rtl/rd_scoreboard_counter.sv
// sb_counter: pending-write counter for one register. Increments on issue,
// decrements by 0..2 on writeback/kill, clamps at 0 and reports underflow.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             underflow,
    output logic [1:0]       dec_done
);

    localparam int W = CNT_W + 2;
    localparam logic [W-1:0] MAX = W'((1 << CNT_W) - 1);

    logic [W-1:0] avail;
    logic [W-1:0] result;

    // Decrements are checked against cnt+inc so issue+retire in one cycle never underflows.
    assign avail     = W'(cnt) + W'(inc);
    assign underflow = W'(dec) > avail;
    assign dec_done  = underflow ? avail[1:0] : dec;
    assign result    = avail - W'(dec_done);
    assign sat       = (cnt == MAX[CNT_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (result > MAX) begin
            cnt <= MAX[CNT_W-1:0];
        end else begin
            cnt <= result[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/rd_scoreboard.sv
// rd_scoreboard: tracks in-flight register writes between issue and writeback/kill
// and answers decode's rs1/rs2 busy queries from the registered counters.
module rd_scoreboard
    import rd_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [4:0]           issue_rd,
    input  logic [4:0]           issue_type,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic [4:0]           wb_type,
    input  logic                 kill_valid,
    input  logic [4:0]           kill_rd,
    input  logic [4:0]           kill_type,
    input  logic [4:0]           rs1_D,
    input  logic [4:0]           rs2_D,
    input  logic [4:0]           type_D,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 stall_D,
    output logic [OUT_W-1:0]     outstanding,
    output logic                 err_underflow
);

    // Handshake: an issue transfers when issue_valid & issue_ready on a rising
    // clk edge; issue_ready never looks at issue_valid, so D may sample it freely.
    logic             issue_has_rd;
    logic             issue_inc;
    logic             wb_dec;
    logic             kill_dec;
    logic [CNT_W-1:0] cnt [NREGS];
    logic [1:0]       dec_done [NREGS];
    logic [NREGS-1:0] sat;
    logic [NREGS-1:0] under;
    logic [OUT_W-1:0] dec_total;
    logic [OUT_W-1:0] outstanding_nxt;

    assign issue_has_rd = (issue_rd != 5'd0) && has_rd(issue_type);
    assign wb_dec       = wb_valid && (wb_rd != 5'd0) && has_rd(wb_type);
    assign kill_dec     = kill_valid && (kill_rd != 5'd0) && has_rd(kill_type);

    assign issue_ready = !(issue_has_rd && sat[issue_rd]
                           && !(wb_dec && (wb_rd == issue_rd))
                           && !(kill_dec && (kill_rd == issue_rd)));
    assign issue_inc   = issue_valid && issue_ready && issue_has_rd;

    // x0 is hard-wired zero and never tracked.
    assign cnt[0]      = '0;
    assign dec_done[0] = 2'd0;
    assign sat[0]      = 1'b0;
    assign under[0]    = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        logic       inc;
        logic [1:0] dec;

        assign inc = issue_inc && (issue_rd == reg_idx_t'(i));
        assign dec = {1'b0, wb_dec && (wb_rd == reg_idx_t'(i))}
                   + {1'b0, kill_dec && (kill_rd == reg_idx_t'(i))};

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc),
            .dec       (dec),
            .cnt       (cnt[i]),
            .sat       (sat[i]),
            .underflow (under[i]),
            .dec_done  (dec_done[i])
        );
    end

    // Only decrements that actually landed count, so outstanding equals the sum of counters.
    always_comb begin
        dec_total = '0;
        for (int i = 1; i < NREGS; i++) begin
            dec_total = dec_total + OUT_W'(dec_done[i]);
        end
        outstanding_nxt = outstanding + OUT_W'(issue_inc) - dec_total;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            outstanding   <= outstanding_nxt;
            err_underflow <= err_underflow | (|under);
        end
    end

    assign busy_rs1 = (rs1_D != 5'd0) && (cnt[rs1_D] != '0);
    assign busy_rs2 = has_rs2(type_D) && (rs2_D != 5'd0) && (cnt[rs2_D] != '0);
    assign stall_D  = busy_rs1 | busy_rs2;

endmodule

// File: tb/tb_rd_scoreboard.sv
// Self-checking bench for rd_scoreboard: directed scenarios plus random traffic
// checked against an integer-array model of pending writes per register.
module tb_rd_scoreboard;

    localparam int MAXC = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_ready;
    logic [4:0] issue_rd, issue_type;
    logic       wb_valid;
    logic [4:0] wb_rd, wb_type;
    logic       kill_valid;
    logic [4:0] kill_rd, kill_type;
    logic [4:0] rs1_D, rs2_D, type_D;
    logic       busy_rs1, busy_rs2, stall_D;
    logic [6:0] outstanding;
    logic       err_underflow;

    rd_scoreboard #(.CNT_W(2), .NREGS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rd      (issue_rd),
        .issue_type    (issue_type),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_type       (wb_type),
        .kill_valid    (kill_valid),
        .kill_rd       (kill_rd),
        .kill_type     (kill_type),
        .rs1_D         (rs1_D),
        .rs2_D         (rs2_D),
        .type_D        (type_D),
        .busy_rs1      (busy_rs1),
        .busy_rs2      (busy_rs2),
        .stall_D       (stall_D),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model + scoreboard ----------------
    int        m_cnt [32];
    int        m_out;
    logic      m_err;
    logic [6:0] exp_q [$];
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic writes_rd(input logic v, input logic [4:0] rd, input logic [4:0] t);
        return v && (rd != 0) && (t[4:3] == 2'b00);
    endfunction

    function automatic logic model_ready();
        if (!writes_rd(1'b1, issue_rd, issue_type)) return 1'b1;
        if (m_cnt[issue_rd] < MAXC) return 1'b1;
        if (writes_rd(wb_valid, wb_rd, wb_type) && wb_rd == issue_rd) return 1'b1;
        if (writes_rd(kill_valid, kill_rd, kill_type) && kill_rd == issue_rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_out = 0;
        m_err = 1'b0;
        exp_q.delete();
        exp_q.push_back(7'd0);
    endtask

    task automatic check_outputs();
        logic e1, e2;
        logic [6:0] eo;
        e1 = (rs1_D != 0) && (m_cnt[rs1_D] != 0);
        e2 = (type_D[2:0] == 3'b000) && (rs2_D != 0) && (m_cnt[rs2_D] != 0);
        check_val("issue_ready", issue_ready, model_ready());
        check_val("busy_rs1", busy_rs1, e1);
        check_val("busy_rs2", busy_rs2, e2);
        check_val("stall_D", stall_D, e1 | e2);
        check_val("err_underflow", err_underflow, m_err);
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 32'd1, 32'd0);
        end else begin
            eo = exp_q.pop_front();
            check_val("outstanding", outstanding, eo);
        end
    endtask

    task automatic model_step();
        int delta [32];
        int n;
        for (int r = 0; r < 32; r++) delta[r] = 0;
        if (issue_valid && model_ready() && writes_rd(1'b1, issue_rd, issue_type)) delta[issue_rd]++;
        if (writes_rd(wb_valid, wb_rd, wb_type)) delta[wb_rd]--;
        if (writes_rd(kill_valid, kill_rd, kill_type)) delta[kill_rd]--;
        for (int r = 1; r < 32; r++) begin
            n = m_cnt[r] + delta[r];
            if (n < 0) begin
                m_err = 1'b1;
                n = 0;
            end
            m_out += n - m_cnt[r];
            m_cnt[r] = n;
        end
        exp_q.push_back(7'(m_out));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        issue_valid = 0; issue_rd = 0; issue_type = 0;
        wb_valid = 0; wb_rd = 0; wb_type = 0;
        kill_valid = 0; kill_rd = 0; kill_type = 0;
        rs1_D = 0; rs2_D = 0; type_D = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one cycle of inputs at negedge, checks outputs, advances the model.
    task automatic do_cycle(input logic iv, input logic [4:0] ird, input logic [4:0] ity,
                            input logic wv, input logic [4:0] wrd, input logic [4:0] wty,
                            input logic kv, input logic [4:0] krd, input logic [4:0] kty,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] td);
        @(negedge clk);
        issue_valid = iv; issue_rd = ird; issue_type = ity;
        wb_valid = wv; wb_rd = wrd; wb_type = wty;
        kill_valid = kv; kill_rd = krd; kill_type = kty;
        rs1_D = r1; rs2_D = r2; type_D = td;
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic idle_cycle(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] td);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, td);
    endtask

    logic [4:0] pool [6] = '{5'd0, 5'd3, 5'd5, 5'd7, 5'd9, 5'd31};

    function automatic logic [4:0] rand_type();
        if ($urandom_range(0, 7) == 0) return 5'b01000;
        return 5'($urandom_range(0, 7));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();
        #3;
        check_val("reset_ready", issue_ready, 1);
        check_val("reset_outstanding", outstanding, 0);
        check_val("reset_err", err_underflow, 0);
        do_reset();

        // Issue x5, busy appears next cycle; retire in cycle 3 clears it next cycle.
        do_cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        check_val("busy5_c0", busy_rs1, 0);
        idle_cycle(5, 0, 0);
        check_val("busy5_c1", busy_rs1, 1);
        idle_cycle(5, 0, 0);
        do_cycle(0, 0, 0, 1, 5, 0, 0, 0, 0, 5, 0, 0);
        check_val("busy5_c3", busy_rs1, 1);
        idle_cycle(5, 0, 0);
        check_val("busy5_c4", busy_rs1, 0);

        // Asynchronous reset mid-cycle with x5 pending.
        do_cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        @(negedge clk);
        set_idle();
        issue_valid = 1; issue_rd = 5; rs1_D = 5;
        #1;
        check_val("pre_rst_busy5", busy_rs1, 1);
        check_val("pre_rst_out", outstanding, 1);
        #1 rst = 1'b1;
        #1;
        check_val("async_rst_busy5", busy_rs1, 0);
        check_val("async_rst_out", outstanding, 0);
        check_val("async_rst_ready", issue_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        model_reset();

        // Saturate x7 (three in flight).
        for (int k = 0; k < 3; k++) do_cycle(1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
        do_cycle(1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
        check_val("sat7_ready", issue_ready, 0);
        do_cycle(1, 8, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0);
        check_val("rd8_ready", issue_ready, 1);
        do_cycle(1, 7, 0, 1, 7, 0, 0, 0, 0, 7, 0, 0);
        check_val("sat7_wb_ready", issue_ready, 1);
        idle_cycle(7, 8, 0);
        check_val("out_after_sat", outstanding, 4);
        do_reset();

        // x3 at 2, then issue+wb+kill on x3 in one cycle -> 1.
        do_cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        do_cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        do_cycle(1, 3, 0, 1, 3, 0, 1, 3, 0, 3, 0, 0);
        check_val("triple_out_before", outstanding, 2);
        idle_cycle(3, 0, 0);
        check_val("triple_out_after", outstanding, 1);
        do_cycle(0, 0, 0, 1, 3, 0, 0, 0, 0, 3, 0, 0);
        idle_cycle(3, 0, 0);
        check_val("x3_drained", busy_rs1, 0);

        // x0 and no-rd type issues change nothing.
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        do_cycle(1, 4, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        idle_cycle(0, 4, 0);
        check_val("no_rd_busy", busy_rs2, 0);
        check_val("no_rd_out", outstanding, 0);

        // Underflow on x9, sticky; rs2 masked by decode type.
        do_cycle(1, 10, 0, 1, 9, 0, 0, 0, 0, 0, 10, 0);
        check_val("err_before", err_underflow, 0);
        idle_cycle(0, 10, 5'b00001);
        check_val("err_after", err_underflow, 1);
        check_val("rs2_masked", busy_rs2, 0);
        idle_cycle(0, 10, 0);
        check_val("rs2_unmasked", busy_rs2, 1);
        check_val("err_sticky", err_underflow, 1);
        do_reset();

        // Random traffic over a small register pool to force collisions.
        for (int c = 0; c < 600; c++) begin
            do_cycle($urandom_range(0, 9) < 6, pool[$urandom_range(0, 5)], rand_type(),
                     $urandom_range(0, 9) < 3, pool[$urandom_range(0, 5)], rand_type(),
                     $urandom_range(0, 9) < 1, pool[$urandom_range(0, 5)], rand_type(),
                     pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)], rand_type());
            if (c == 300) do_reset();
        end
        idle_cycle(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
